// File: rtl/serial_sync_frame_tx.sv
// Serial frame transmitter: 1011 sync header, MSB-first payload, optional even parity, guard zeros.
// Optional parity bit is compiled in when SERIAL_SYNC_FRAME_TX_PARITY_EN is defined.
module serial_sync_frame_tx #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned GAP_LEN = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out,
  output logic              out_valid,
  output logic              frame_done
);

  localparam int unsigned CNT_MAX = (DATA_W > GAP_LEN) ? ((DATA_W > 4) ? DATA_W : 4)
                                                       : ((GAP_LEN > 4) ? GAP_LEN : 4);
  localparam int unsigned CNT_W   = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(3);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);
  localparam logic [3:0]       HDR       = 4'b1011;

`ifdef SERIAL_SYNC_FRAME_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, SYNC, DATA, PAR, GAP} state_t;
  localparam bit PAR_EN = 1'b1;
  logic par;
`else
  typedef enum logic [2:0] {IDLE, SYNC, DATA, GAP} state_t;
  localparam bit PAR_EN = 1'b0;
`endif

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] shreg;

  // Ready is a pure function of state; reset masks it so nothing is accepted while held.
  assign in_ready = (state == IDLE) && !rst;

  // State register and registered outputs: out always holds the bit of the current state/cnt.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      shreg      <= '0;
      out        <= 1'b0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
`ifdef SERIAL_SYNC_FRAME_TX_PARITY_EN
      par        <= 1'b0;
`endif
    end else begin
      frame_done <= 1'b0;
      unique case (state)
        IDLE: begin
          out       <= 1'b0;
          out_valid <= 1'b0;
          if (in_valid) begin
            state     <= SYNC;
            cnt       <= '0;
            shreg     <= in_data;
            out       <= HDR[3];
            out_valid <= 1'b1;
`ifdef SERIAL_SYNC_FRAME_TX_PARITY_EN
            par       <= ^in_data;
`endif
          end
        end
        SYNC: begin
          if (cnt == SYNC_LAST) begin
            state      <= DATA;
            cnt        <= '0;
            out        <= shreg[DATA_W-1];
            shreg      <= shreg << 1;
            frame_done <= (DATA_W == 1) && !PAR_EN;
          end else begin
            cnt <= cnt + CNT_W'(1);
            out <= HDR[2'(CNT_W'(2) - cnt)];
          end
        end
        DATA: begin
          if (cnt == DATA_LAST) begin
`ifdef SERIAL_SYNC_FRAME_TX_PARITY_EN
            state      <= PAR;
            out        <= par;
            frame_done <= 1'b1;
`else
            state     <= (GAP_LEN == 0) ? IDLE : GAP;
            cnt       <= '0;
            out       <= 1'b0;
            out_valid <= 1'b0;
`endif
          end else begin
            cnt        <= cnt + CNT_W'(1);
            out        <= shreg[DATA_W-1];
            shreg      <= shreg << 1;
            frame_done <= ((cnt + CNT_W'(1)) == DATA_LAST) && !PAR_EN;
          end
        end
`ifdef SERIAL_SYNC_FRAME_TX_PARITY_EN
        PAR: begin
          state     <= (GAP_LEN == 0) ? IDLE : GAP;
          cnt       <= '0;
          out       <= 1'b0;
          out_valid <= 1'b0;
        end
`endif
        GAP: begin
          out       <= 1'b0;
          out_valid <= 1'b0;
          if (cnt == GAP_LAST) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state     <= IDLE;
          cnt       <= '0;
          out       <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sync_frame_tx.sv
// Scoreboard bench for serial_sync_frame_tx: per-cycle expected {in_ready,out,out_valid,frame_done}.
module tb_serial_sync_frame_tx;

`ifdef SERIAL_SYNC_FRAME_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int GAP = 2;
  localparam logic [3:0] HDR = 4'b1011;

  logic       clk, rst;
  logic       in_valid, in_ready, out, out_valid, frame_done;
  logic [7:0] in_data;
  logic       in_valid2, in_ready2, out2, out_valid2, frame_done2;
  logic [0:0] in_data2;

  int n_cmp = 0;
  int n_err = 0;
  int acc_cnt = 0;
  int det_hits = 0;
  logic [3:0] q[$];
  logic [2:0] det_st;

  serial_sync_frame_tx #(.DATA_W(8), .GAP_LEN(GAP)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out(out), .out_valid(out_valid), .frame_done(frame_done));

  serial_sync_frame_tx #(.DATA_W(1), .GAP_LEN(0)) dut_short (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_data(in_data2), .in_ready(in_ready2),
    .out(out2), .out_valid(out_valid2), .frame_done(frame_done2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (!rst && in_valid && in_ready) acc_cnt++;

  // Overlapping Moore 1011 detector fed from the serial output.
  always @(posedge clk) begin
    if (rst) det_st <= 3'd0;
    else case (det_st)
      3'd0:    det_st <= out ? 3'd1 : 3'd0;
      3'd1:    det_st <= out ? 3'd1 : 3'd2;
      3'd2:    det_st <= out ? 3'd3 : 3'd0;
      3'd3:    det_st <= out ? 3'd4 : 3'd2;
      default: det_st <= out ? 3'd1 : 3'd2;
    endcase
  end
  always @(negedge clk) if (det_st == 3'd4) det_hits++;

  // Expected per-cycle vectors from the cycle after accept through the first ready cycle.
  function automatic void push_frame(input logic [31:0] d, input int dw, input int gl);
    logic p;
    p = 1'b0;
    for (int k = 0; k < 4; k++) q.push_back({1'b0, HDR[3-k], 1'b1, 1'b0});
    for (int j = 0; j < dw; j++) begin
      p = p ^ d[j];
      q.push_back({1'b0, d[dw-1-j], 1'b1, 1'((P == 0) && (j == dw - 1))});
    end
    if (P == 1) q.push_back({1'b0, p, 1'b1, 1'b1});
    for (int g = 0; g < gl; g++) q.push_back(4'b0000);
    q.push_back(4'b1000);
  endfunction

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_valid2 = 1'b0; in_data2 = '0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({in_ready, out, out_valid, frame_done} !== 4'b0000) begin
      n_err++; $display("FAIL reset_outputs: got %b expected 0000", {in_ready, out, out_valid, frame_done});
    end
    n_cmp++;
    if ({in_ready2, out2, out_valid2, frame_done2} !== 4'b0000) begin
      n_err++; $display("FAIL reset_outputs_short: got %b expected 0000", {in_ready2, out2, out_valid2, frame_done2});
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({in_ready, in_ready2} !== 2'b11) begin
      n_err++; $display("FAIL ready_after_reset: got %b expected 11", {in_ready, in_ready2});
    end
  endtask

  task automatic test_frame(input logic [7:0] d);
    int n;
    logic [3:0] e, got;
    in_data = d; in_valid = 1'b1;
    n_cmp++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL ready_before_accept: got %b expected 1", in_ready); end
    @(posedge clk);
    push_frame(32'(d), 8, GAP);
    n = q.size();
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(posedge clk);
      #1;
      e = q.pop_front();
      got = {in_ready, out, out_valid, frame_done};
      n_cmp++;
      if (got !== e) begin
        n_err++; $display("FAIL frame_%h cycle %0d: got %b expected %b", d, i + 1, got, e);
      end
      if (i == 0) in_valid = 1'b0;
      if (i == 2) in_data = ~d;
    end
  endtask

  task automatic test_back_to_back();
    int n, acc0;
    logic [3:0] e, got;
    acc0 = acc_cnt;
    in_data = 8'hFF; in_valid = 1'b1;
    @(posedge clk);
    push_frame(32'hFF, 8, GAP);
    for (int f = 0; f < 2; f++) begin
      if (f == 1) begin
        @(posedge clk);
        push_frame(32'h00, 8, GAP);
      end
      n = q.size();
      for (int i = 0; i < n; i++) begin
        if (i > 0) @(posedge clk);
        #1;
        e = q.pop_front();
        got = {in_ready, out, out_valid, frame_done};
        n_cmp++;
        if (got !== e) begin
          n_err++; $display("FAIL b2b_frame%0d cycle %0d: got %b expected %b", f, i + 1, got, e);
        end
        if (f == 0 && i == 2) in_data = 8'h00;
        if (f == 1 && i == 0) in_valid = 1'b0;
        if (f == 1 && i == 2) in_data = 8'h5A;
      end
    end
    n_cmp++;
    if (acc_cnt - acc0 !== 2) begin
      n_err++; $display("FAIL b2b_accepts: got %0d expected 2", acc_cnt - acc0);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [3:0] e, got;
    in_data = 8'hA5; in_valid = 1'b1;
    @(posedge clk);
    push_frame(32'hA5, 8, GAP);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(posedge clk);
      #1;
      e = q.pop_front();
      got = {in_ready, out, out_valid, frame_done};
      n_cmp++;
      if (got !== e) begin
        n_err++; $display("FAIL pre_reset cycle %0d: got %b expected %b", i + 1, got, e);
      end
      if (i == 0) in_valid = 1'b0;
    end
    rst = 1'b1;
    q.delete();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      got = {in_ready, out, out_valid, frame_done};
      n_cmp++;
      if (got !== 4'b0000) begin
        n_err++; $display("FAIL mid_reset cycle %0d: got %b expected 0000", i + 7, got);
      end
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL ready_after_mid_reset: got %b expected 1", in_ready); end
    test_frame(8'h3C);
  endtask

  task automatic test_short_frame();
    int n;
    logic [3:0] e, got;
    in_data2 = 1'b1; in_valid2 = 1'b1;
    n_cmp++;
    if (in_ready2 !== 1'b1) begin n_err++; $display("FAIL short_ready: got %b expected 1", in_ready2); end
    @(posedge clk);
    push_frame(32'h1, 1, 0);
    n = q.size();
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(posedge clk);
      #1;
      e = q.pop_front();
      got = {in_ready2, out2, out_valid2, frame_done2};
      n_cmp++;
      if (got !== e) begin
        n_err++; $display("FAIL short_frame cycle %0d: got %b expected %b", i + 1, got, e);
      end
      if (i == 0) in_valid2 = 1'b0;
    end
  endtask

  task automatic test_loopback();
    int n, hits0;
    logic [3:0] e, got;
    hits0 = det_hits;
    in_data = 8'h00; in_valid = 1'b1;
    @(posedge clk);
    push_frame(32'h00, 8, GAP);
    for (int f = 0; f < 2; f++) begin
      if (f == 1) begin
        @(posedge clk);
        push_frame(32'h00, 8, GAP);
      end
      n = q.size();
      for (int i = 0; i < n; i++) begin
        if (i > 0) @(posedge clk);
        #1;
        e = q.pop_front();
        got = {in_ready, out, out_valid, frame_done};
        n_cmp++;
        if (got !== e) begin
          n_err++; $display("FAIL loop_frame%0d cycle %0d: got %b expected %b", f, i + 1, got, e);
        end
        if (i == 4) begin
          n_cmp++;
          if (det_st !== 3'd4) begin
            n_err++; $display("FAIL loop_detect%0d: got state %0d expected 4", f, det_st);
          end
        end
        if (f == 1 && i == 0) in_valid = 1'b0;
      end
    end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (det_hits - hits0 !== 2) begin
      n_err++; $display("FAIL loop_hits: got %0d expected 2", det_hits - hits0);
    end
  endtask

  initial begin
    test_reset();
    test_frame(8'hA5);
    test_frame(8'h07);
    test_back_to_back();
    test_reset_mid_frame();
    test_short_frame();
    test_loopback();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/serial_sync_frame_tx.md
# serial_sync_frame_tx

Serial frame transmitter that drives a single-bit stream into the team's sequence-detector receivers. Each accepted parallel word goes out as a 4-bit sync header `1011`, then the data word MSB first, then an optional parity bit, then a run of guard zeros. The block sits upstream of the Moore `1011` detector and gives it a framed, deterministic bit stream.

## Interface
Parameters:
- `DATA_W`, default 8: payload width in bits; legal range 1..32.
- `GAP_LEN`, default 2: number of guard-zero cycles after each frame; legal range 0..15.

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  upstream word valid.
- `in_data`  in  DATA_W  word to transmit.
- `in_ready`  out  1  block can accept a word.
- `out`  out  1  serial bit, registered.
- `out_valid`  out  1  `out` carries a frame bit (header, data or parity).
- `frame_done`  out  1  one-cycle pulse on the last frame bit.

## Operation
- FSM states and transitions:
  - `IDLE` -> `SYNC` on accept, which is `in_valid && in_ready`.
  - `SYNC` runs 4 cycles -> `DATA`.
  - `DATA` runs DATA_W cycles -> `PAR` if parity is enabled, else `GAP`.
  - `PAR` runs 1 cycle -> `GAP`.
  - `GAP` runs GAP_LEN cycles -> `IDLE`.
  - If GAP_LEN=0, the last frame state goes directly to `IDLE`.
- `in_ready` = 1 only in `IDLE` with `rst` low. It is derived from state, with no combinational path from `in_valid`.
- On accept, `in_data` is captured into a shift register. Later changes to `in_data` have no effect on the frame in flight.
- Header bits are `1`, `0`, `1`, `1`, in that order.
- Data is sent MSB first: bit DATA_W-1 down to bit 0.
- A bit counter is sized to cover max(4, DATA_W, GAP_LEN). It reloads on every state entry.
- In `GAP` and `IDLE`: `out`=0 and `out_valid`=0.
- `in_valid` while not in `IDLE` is ignored; the word stays pending upstream.
- Reset mid-frame: at the next edge with `rst`=1 the frame is abandoned. The state becomes `IDLE`, and `out`, `out_valid` and `frame_done` go to 0. No partial-frame completion and no `frame_done` pulse.

## Timing
- Reset values: `out`=0, `out_valid`=0, `frame_done`=0, state `IDLE`, `in_ready`=1 from the first cycle after `rst` is released.
- Let cycle 0 be the accept edge. Header bit k is on `out` in cycles 1..4, k=0..3.
- Data bit DATA_W-1-j is on `out` in cycle 5+j.
- Parity bit, when enabled, is in cycle 5+DATA_W.
- `frame_done`=1 for exactly one cycle, aligned with the final frame bit:
  - cycle 4+DATA_W without parity;
  - cycle 5+DATA_W with parity.
- The guard zeros follow immediately. `in_ready` is high again in the cycle after the last guard cycle.
- Minimum accept-to-accept spacing: 4 + DATA_W + P + GAP_LEN + 1 cycles, where P = 1 when parity is enabled, else 0.
  - Default: 15 cycles without parity, 16 with.

## Configuration
- `SERIAL_SYNC_FRAME_TX_PARITY_EN`
  - Defined: the `PAR` state is compiled in and one even-parity bit (XOR of the captured word) is sent after the data bit. `out_valid`=1 on that bit, and it carries `frame_done`.
  - Undefined: no `PAR` state and no parity logic; frame length is 4+DATA_W.

## Test plan
- Defaults, no parity, `in_data`=8'hA5 accepted at cycle 0 -> `out` over cycles 1..12 = `1011_10100101`; `out_valid`=1 exactly in cycles 1..12; `frame_done` only in cycle 12; `out`=0 in cycles 13..14; `in_ready`=1 at cycle 15.
- Parity enabled, `in_data`=8'hA5 -> parity bit 0 in cycle 13 with `frame_done`; `in_data`=8'h07 -> parity bit 1.
- Back-to-back: `in_valid` held high with 8'hFF then 8'h00 -> second accept exactly at the minimum spacing; `in_data` changes mid-frame do not corrupt the first frame.
- `rst` asserted in cycle 6 of a frame -> from the next cycle `out`=0, `out_valid`=0, no `frame_done` pulse; a new frame can be accepted after `rst` falls.
- GAP_LEN=0, DATA_W=1, `in_data`=1 -> `out` = `1011_1`; `in_ready` high in cycle 6.
- Loopback into the `1011` Moore detector with payload 8'h00 -> detector output asserts exactly once per frame, from the header.
